// File: rtl/microsequencer_if.sv
// Bus bundle between the microsequencer, the control ROM, the instruction encoder
// and the datapath condition logic.
interface microsequencer_if #(
    parameter int AW = 8,
    parameter int CW = 64
);
    logic          EN;
    logic [CW-1:0] ROM_OUT;
    logic [AW-1:0] ENC_ADDR;
    logic [7:0]    COND;
    logic          MOC;
    logic [AW-1:0] ROM_ADDR;
    logic [CW-1:0] CTRL;
    logic          ERR;

    modport slave (
        input  EN, ROM_OUT, ENC_ADDR, COND, MOC,
        output ROM_ADDR, CTRL, ERR
    );

    modport master (
        output EN, ROM_OUT, ENC_ADDR, COND, MOC,
        input  ROM_ADDR, CTRL, ERR
    );
endinterface

// File: rtl/microsequencer.sv
// Microprogram next-address sequencer: addresses the control ROM, registers the
// returned word into CTRL and keeps a small return stack for microsubroutines.
module microsequencer #(
    parameter int            AW          = 8,
    parameter int            CW          = 64,
    parameter int            STACK_DEPTH = 4,
    parameter logic [AW-1:0] RESET_ADDR  = {AW{1'b0}}
) (
    input  logic           Clk,
    input  logic           Clr,
    microsequencer_if.slave bus
);
    localparam int             SPW     = $clog2(STACK_DEPTH) + 1;
    localparam logic [SPW-1:0] SP_FULL = SPW'(STACK_DEPTH);

    logic [AW-1:0]  addr_q, addr_d;
    logic [CW-1:0]  ctrl_q, ctrl_d;
    logic [SPW-1:0] sp_q, sp_d;
    logic [AW-1:0]  stack_q [STACK_DEPTH];
    logic [AW-1:0]  stack_d [STACK_DEPTH];
    logic           err_q, err_d;

    logic [2:0]     n_s;
    logic           inv_s;
    logic           mi_s;
    logic [2:0]     s_s;
    logic [AW-1:0]  t_s;
    logic           cond_s;
    logic [AW-1:0]  inc_s;
    logic [SPW-1:0] sp_dec_s;

    assign n_s      = bus.ROM_OUT[57:55];
    assign inv_s    = bus.ROM_OUT[54];
    assign mi_s     = bus.ROM_OUT[53];
    assign s_s      = bus.ROM_OUT[52:50];
    assign t_s      = bus.ROM_OUT[34 +: AW];
    assign cond_s   = (mi_s ? bus.MOC : bus.COND[s_s]) ^ inv_s;
    assign inc_s    = addr_q + {{(AW-1){1'b0}}, 1'b1};
    assign sp_dec_s = sp_q - {{(SPW-1){1'b0}}, 1'b1};

    // Next-address selection and return-stack update
    always_comb begin
        addr_d  = addr_q;
        ctrl_d  = ctrl_q;
        sp_d    = sp_q;
        stack_d = stack_q;
        err_d   = err_q;
        if (bus.EN) begin
            ctrl_d = bus.ROM_OUT;
            case (n_s)
                3'b000:  addr_d = bus.ENC_ADDR;
                3'b001:  addr_d = t_s;
                3'b010:  addr_d = inc_s;
                3'b011:  addr_d = cond_s ? t_s : inc_s;
                3'b100:  addr_d = cond_s ? t_s : bus.ENC_ADDR;
                3'b101: begin
                    addr_d = t_s;
                    if (sp_q == SP_FULL) begin
                        err_d = 1'b1;
                    end else begin
                        stack_d[sp_q[SPW-2:0]] = inc_s;
                        sp_d = sp_q + {{(SPW-1){1'b0}}, 1'b1};
                    end
                end
                3'b110: begin
                    // Underflow restarts the fetch microroutine rather than jumping to garbage
                    if (sp_q == {SPW{1'b0}}) begin
                        addr_d = RESET_ADDR;
                        err_d  = 1'b1;
                    end else begin
                        addr_d = stack_q[sp_dec_s[SPW-2:0]];
                        sp_d   = sp_dec_s;
                    end
                end
                3'b111:  addr_d = cond_s ? inc_s : addr_q;
                default: addr_d = inc_s;
            endcase
        end else begin
            addr_d = addr_q;
        end
    end

    // State, control register, stack and fault flag
    always_ff @(posedge Clk or negedge Clr) begin
        if (!Clr) begin
            addr_q <= RESET_ADDR;
            ctrl_q <= {CW{1'b0}};
            sp_q   <= {SPW{1'b0}};
            err_q  <= 1'b0;
            for (int i = 0; i < STACK_DEPTH; i++) begin
                stack_q[i] <= {AW{1'b0}};
            end
        end else begin
            addr_q  <= addr_d;
            ctrl_q  <= ctrl_d;
            sp_q    <= sp_d;
            err_q   <= err_d;
            stack_q <= stack_d;
        end
    end

    assign bus.ROM_ADDR = addr_q;
    assign bus.CTRL     = ctrl_q;
    assign bus.ERR      = err_q;
endmodule

// File: tb/tb_microsequencer.sv
// Directed self-checking bench for microsequencer with a behavioural control ROM.
module tb_microsequencer;
    logic Clk;
    logic Clr;
    int   checks;
    int   errors;
    logic [63:0] rom [256];

    microsequencer_if #(.AW(8), .CW(64)) bus ();

    microsequencer #(.AW(8), .CW(64), .STACK_DEPTH(4), .RESET_ADDR(8'h00)) dut (
        .Clk (Clk),
        .Clr (Clr),
        .bus (bus.slave)
    );

    assign bus.ROM_OUT = rom[bus.ROM_ADDR];

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic logic [63:0] mk(input logic [2:0] n, input logic inv, input logic mi,
                                       input logic [2:0] s, input logic [7:0] t, input logic [7:0] tag);
        logic [63:0] w;
        w = 64'h0;
        w[63:58] = 6'h2A;
        w[57:55] = n;
        w[54]    = inv;
        w[53]    = mi;
        w[52:50] = s;
        w[49:42] = tag;
        w[41:34] = t;
        w[7:0]   = tag;
        return w;
    endfunction

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 256; i++) rom[i] = mk(3'b010, 1'b0, 1'b0, 3'd0, 8'h00, 8'(i));
    endtask

    task automatic do_reset();
        Clr = 1'b0;
        tick();
        tick();
        Clr = 1'b1;
    endtask

    task automatic test_reset();
        clear_rom();
        rom[1] = mk(3'b001, 1'b0, 1'b0, 3'd0, 8'h03, 8'h01);
        Clr = 1'b0;
        tick();
        tick();
        checks++; if (bus.ROM_ADDR !== 8'h00) begin errors++; $display("FAIL reset_addr: got %h expected 00", bus.ROM_ADDR); end
        checks++; if (bus.CTRL !== 64'h0) begin errors++; $display("FAIL reset_ctrl: got %h expected 0", bus.CTRL); end
        checks++; if (bus.ERR !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", bus.ERR); end
        Clr = 1'b1;
        tick();
        checks++; if (bus.ROM_ADDR !== 8'h01) begin errors++; $display("FAIL run_addr1: got %h expected 01", bus.ROM_ADDR); end
        checks++; if (bus.CTRL !== rom[0]) begin errors++; $display("FAIL run_ctrl1: got %h expected %h", bus.CTRL, rom[0]); end
        tick();
        checks++; if (bus.ROM_ADDR !== 8'h03) begin errors++; $display("FAIL run_addr2: got %h expected 03", bus.ROM_ADDR); end
        checks++; if (bus.CTRL !== rom[1]) begin errors++; $display("FAIL run_ctrl2: got %h expected %h", bus.CTRL, rom[1]); end
    endtask

    task automatic test_dispatch();
        logic [7:0] exp_a [5];
        exp_a = '{8'h04, 8'h1A, 8'h20, 8'h21, 8'h60};
        clear_rom();
        rom[8'h00] = mk(3'b001, 1'b0, 1'b0, 3'd0, 8'h04, 8'h00);
        rom[8'h04] = mk(3'b000, 1'b0, 1'b0, 3'd0, 8'h99, 8'h04);
        rom[8'h1A] = mk(3'b011, 1'b0, 1'b0, 3'd2, 8'h20, 8'h1A);
        rom[8'h20] = mk(3'b011, 1'b1, 1'b0, 3'd2, 8'h50, 8'h20);
        rom[8'h21] = mk(3'b100, 1'b0, 1'b0, 3'd2, 8'h60, 8'h21);
        rom[8'h60] = mk(3'b100, 1'b1, 1'b0, 3'd2, 8'h70, 8'h60);
        bus.ENC_ADDR = 8'h1A;
        bus.COND     = 8'b0000_0100;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (bus.ROM_ADDR !== exp_a[i]) begin errors++; $display("FAIL dispatch_%0d: got %h expected %h", i, bus.ROM_ADDR, exp_a[i]); end
        end
        tick();
        checks++; if (bus.ROM_ADDR !== 8'h1A) begin errors++; $display("FAIL cond_enc: got %h expected 1a", bus.ROM_ADDR); end
    endtask

    task automatic test_moc_wait();
        clear_rom();
        rom[0] = mk(3'b001, 1'b0, 1'b0, 3'd0, 8'h03, 8'h00);
        rom[3] = mk(3'b111, 1'b0, 1'b1, 3'd0, 8'h00, 8'h03);
        bus.COND = 8'hFF;
        bus.MOC  = 1'b0;
        do_reset();
        tick();
        checks++; if (bus.ROM_ADDR !== 8'h03) begin errors++; $display("FAIL wait_enter: got %h expected 03", bus.ROM_ADDR); end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (bus.ROM_ADDR !== 8'h03 || bus.CTRL !== rom[3])
                begin errors++; $display("FAIL wait_hold_%0d: got %h/%h expected 03/%h", i, bus.ROM_ADDR, bus.CTRL, rom[3]); end
        end
        bus.MOC = 1'b1;
        tick();
        checks++; if (bus.ROM_ADDR !== 8'h04) begin errors++; $display("FAIL wait_release: got %h expected 04", bus.ROM_ADDR); end
        bus.MOC = 1'b0;
    endtask

    task automatic test_subroutine();
        logic [7:0] exp_a [6];
        exp_a = '{8'h10, 8'h30, 8'h31, 8'h40, 8'h32, 8'h11};
        clear_rom();
        rom[8'h00] = mk(3'b001, 1'b0, 1'b0, 3'd0, 8'h10, 8'h00);
        rom[8'h10] = mk(3'b101, 1'b0, 1'b0, 3'd0, 8'h30, 8'h10);
        rom[8'h31] = mk(3'b101, 1'b0, 1'b0, 3'd0, 8'h40, 8'h31);
        rom[8'h40] = mk(3'b110, 1'b0, 1'b0, 3'd0, 8'h00, 8'h40);
        rom[8'h32] = mk(3'b110, 1'b0, 1'b0, 3'd0, 8'h00, 8'h32);
        do_reset();
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++; if (bus.ROM_ADDR !== exp_a[i]) begin errors++; $display("FAIL sub_%0d: got %h expected %h", i, bus.ROM_ADDR, exp_a[i]); end
        end
        checks++; if (bus.ERR !== 1'b0) begin errors++; $display("FAIL sub_err: got %b expected 0", bus.ERR); end
    endtask

    task automatic test_stack_faults();
        clear_rom();
        rom[8'h00] = mk(3'b101, 1'b0, 1'b0, 3'd0, 8'h80, 8'h00);
        for (int i = 0; i < 4; i++) rom[8'h80 + i] = mk(3'b101, 1'b0, 1'b0, 3'd0, 8'(8'h81 + i), 8'(8'h80 + i));
        do_reset();
        for (int i = 0; i < 4; i++) tick();
        checks++; if (bus.ROM_ADDR !== 8'h83 || bus.ERR !== 1'b0) begin errors++; $display("FAIL ovf_pre: got %h/%b expected 83/0", bus.ROM_ADDR, bus.ERR); end
        tick();
        checks++; if (bus.ROM_ADDR !== 8'h84 || bus.ERR !== 1'b1) begin errors++; $display("FAIL ovf: got %h/%b expected 84/1", bus.ROM_ADDR, bus.ERR); end
        clear_rom();
        rom[8'h00] = mk(3'b001, 1'b0, 1'b0, 3'd0, 8'h05, 8'h00);
        rom[8'h05] = mk(3'b110, 1'b0, 1'b0, 3'd0, 8'h00, 8'h05);
        do_reset();
        checks++; if (bus.ERR !== 1'b0) begin errors++; $display("FAIL err_reset: got %b expected 0", bus.ERR); end
        tick();
        tick();
        checks++; if (bus.ROM_ADDR !== 8'h00 || bus.ERR !== 1'b1) begin errors++; $display("FAIL udf: got %h/%b expected 00/1", bus.ROM_ADDR, bus.ERR); end
        tick();
        checks++; if (bus.ROM_ADDR !== 8'h05 || bus.ERR !== 1'b1) begin errors++; $display("FAIL err_sticky: got %h/%b expected 05/1", bus.ROM_ADDR, bus.ERR); end
        clear_rom();
        rom[8'h00] = mk(3'b001, 1'b0, 1'b0, 3'd0, 8'hFF, 8'h00);
        do_reset();
        tick();
        tick();
        checks++; if (bus.ROM_ADDR !== 8'h00) begin errors++; $display("FAIL wrap: got %h expected 00", bus.ROM_ADDR); end
    endtask

    task automatic test_freeze_and_async_reset();
        clear_rom();
        rom[8'h02] = mk(3'b101, 1'b0, 1'b0, 3'd0, 8'h00, 8'h02);
        do_reset();
        tick();
        bus.EN = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (bus.ROM_ADDR !== 8'h01 || bus.CTRL !== rom[0] || bus.ERR !== 1'b0)
                begin errors++; $display("FAIL freeze_%0d: got %h/%h expected 01/%h", i, bus.ROM_ADDR, bus.CTRL, rom[0]); end
        end
        bus.EN = 1'b1;
        tick();
        checks++; if (bus.ROM_ADDR !== 8'h02 || bus.CTRL !== rom[1]) begin errors++; $display("FAIL unfreeze: got %h/%h expected 02/%h", bus.ROM_ADDR, bus.CTRL, rom[1]); end
        clear_rom();
        rom[0] = mk(3'b001, 1'b0, 1'b0, 3'd0, 8'h03, 8'h00);
        rom[3] = mk(3'b111, 1'b0, 1'b1, 3'd0, 8'h00, 8'h03);
        bus.MOC = 1'b0;
        do_reset();
        tick();
        tick();
        #2;
        Clr = 1'b0;
        #1;
        checks++; if (bus.ROM_ADDR !== 8'h00 || bus.CTRL !== 64'h0) begin errors++; $display("FAIL async_rst: got %h/%h expected 00/0", bus.ROM_ADDR, bus.CTRL); end
        tick();
        Clr = 1'b1;
        tick();
        checks++; if (bus.ROM_ADDR !== 8'h03 || bus.CTRL !== rom[0]) begin errors++; $display("FAIL post_rst: got %h/%h expected 03/%h", bus.ROM_ADDR, bus.CTRL, rom[0]); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        Clr = 1'b1;
        bus.EN = 1'b1;
        bus.ENC_ADDR = 8'h00;
        bus.COND = 8'h00;
        bus.MOC = 1'b0;
        test_reset();
        test_dispatch();
        test_moc_wait();
        test_subroutine();
        test_stack_faults();
        test_freeze_and_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
